if_fetch_unit: RTL and testbench

//  Fetch-side consumer of the branch bus driven by the issue stage. Owns the PC.

---
 rtl/if_fetch_unit_pkg.sv | 17 +
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_queue.sv | 70 +++++++
 rtl/if_fetch_unit.sv | 60 ++++++
 tb/tb_if_fetch_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, reset PC, fetch-queue entry type and PC helper
package if_fetch_unit_pkg;
    localparam int BR_BUS_WD = 33;
    localparam int FS_TO_DS_BUS_WD = 64;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        done;
        logic        cancel;
    } fq_entry_t;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: branch bus, decode handshake and instruction-SRAM bus of the fetch stage
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       ds_allowin;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_req;
    logic [31:0]                inst_sram_addr;
    logic                       inst_sram_addr_ok;
    logic                       inst_sram_data_ok;
    logic [31:0]                inst_sram_rdata;

    modport master (
        input  br_bus, ds_allowin, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_addr
    );

    modport slave (
        output br_bus, ds_allowin, inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus, inst_sram_req, inst_sram_addr
    );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: in-order ring of outstanding/buffered fetches with alloc, fill and head pointers
module if_fetch_queue
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic        fill,
    input  logic [31:0] fill_inst,
    input  logic        pop,
    input  logic        cancel_all,
    output logic        full,
    output logic        has_undone,
    output logic        head_valid,
    output logic        head_done,
    output logic        head_cancel,
    output logic [31:0] head_pc,
    output logic [31:0] head_inst
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("if_fetch_queue: DEPTH must be a power of 2 and >= 2");
    end

    logic [AW-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [CW-1:0] cnt, undone_cnt;
    fq_entry_t     ent [DEPTH];

    assign full        = cnt == CW'(DEPTH);
    assign has_undone  = undone_cnt != '0;
    assign head_valid  = cnt != '0;
    assign head_done   = ent[head_ptr].done;
    assign head_cancel = ent[head_ptr].cancel;
    assign head_pc     = ent[head_ptr].pc;
    assign head_inst   = ent[head_ptr].inst;

    // Allocate on accept, fill on return, retire at head; a redirect marks every slot cancelled and
    // the freshly allocated slot (never valid before) clears its own mark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            cnt        <= '0;
            undone_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            if (cancel_all) for (int i = 0; i < DEPTH; i++) ent[i].cancel <= 1'b1;
            if (push) begin
                ent[alloc_ptr].pc     <= push_pc;
                ent[alloc_ptr].done   <= 1'b0;
                ent[alloc_ptr].cancel <= 1'b0;
                alloc_ptr             <= alloc_ptr + AW'(1);
            end
            if (fill) begin
                ent[fill_ptr].inst <= fill_inst;
                ent[fill_ptr].done <= 1'b1;
                fill_ptr           <= fill_ptr + AW'(1);
            end
            if (pop) head_ptr <= head_ptr + AW'(1);
            cnt        <= cnt + CW'(push) - CW'(pop);
            undone_cnt <= undone_cnt + CW'(push) - CW'(fill);
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing in-order SRAM fetches and delivering {inst,pc} to decode
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    if_fetch_unit_if.master  fs
);
    logic        started;
    logic [31:0] pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        full, has_undone, head_valid, head_done, head_cancel;
    logic [31:0] head_pc, head_inst;
    logic        accept, fill, pop;

    assign {br_taken, br_target} = fs.br_bus;
    assign fs.inst_sram_req      = started & ~full & ~br_taken;
    assign fs.inst_sram_addr     = pc;
    assign accept                = fs.inst_sram_req & fs.inst_sram_addr_ok;
    assign fill                  = fs.inst_sram_data_ok & has_undone;
    assign fs.fs_to_ds_valid     = head_valid & head_done & ~head_cancel & ~br_taken;
    assign fs.fs_to_ds_bus       = {head_inst, head_pc};
    assign pop                   = (fs.fs_to_ds_valid & fs.ds_allowin) | (head_valid & head_done & head_cancel);

    // PC advances on each accepted request; a redirect wins (and blocks req in that cycle).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started <= 1'b0;
            pc      <= RESET_PC;
        end else begin
            started <= 1'b1;
            pc      <= br_taken ? br_target : accept ? next_pc(pc) : pc;
        end
    end

    if_fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_pc    (pc),
        .fill       (fill),
        .fill_inst  (fs.inst_sram_rdata),
        .pop        (pop),
        .cancel_all (br_taken),
        .full       (full),
        .has_undone (has_undone),
        .head_valid (head_valid),
        .head_done  (head_done),
        .head_cancel(head_cancel),
        .head_pc    (head_pc),
        .head_inst  (head_inst)
    );

    stray_data_ok: assert property (@(posedge clk) disable iff (reset) fs.inst_sram_data_ok |-> has_undone)
        else $error("inst_sram_data_ok with no outstanding fetch");
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench with an SRAM model returning pc^A5A5A5A5
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RPC = 32'h1c000000;
    localparam logic [31:0] KEY = 32'ha5a5a5a5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    if_fetch_unit_if f();

    if_fetch_unit #(.DEPTH(4), .RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .fs(f));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic aok = 1'b0, dok = 1'b0, allow = 1'b1, br_now = 1'b0;
    logic [31:0] br_tgt = 32'h0;
    logic s_req, s_valid;
    logic [31:0] s_addr;
    logic [63:0] s_bus;
    logic [31:0] sram_q[$];
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc ^ KEY, pc};
    endfunction

    task automatic drive();
        f.br_bus            = {br_now, br_tgt};
        f.ds_allowin        = allow;
        f.inst_sram_addr_ok = aok;
        f.inst_sram_data_ok = dok && sram_q.size() > 0;
        f.inst_sram_rdata   = 32'h0;
        if (sram_q.size() > 0) f.inst_sram_rdata = sram_q[0] ^ KEY;
    endtask

    task automatic tick();
        @(negedge clk);
        drive();
        #1;
        s_req   = f.inst_sram_req;
        s_addr  = f.inst_sram_addr;
        s_valid = f.fs_to_ds_valid;
        s_bus   = f.fs_to_ds_bus;
        if (s_valid && allow) got_q.push_back(s_bus);
        if (f.inst_sram_data_ok) void'(sram_q.pop_front());
        if (s_req && aok) sram_q.push_back(s_addr);
        br_now = 1'b0;
    endtask

    task automatic do_reset();
        aok = 1'b0; dok = 1'b0; allow = 1'b1; br_now = 1'b0;
        drive();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sram_q.delete(); got_q.delete(); exp_q.delete();
        @(posedge clk);
    endtask

    task automatic test_reset();
        aok = 1'b0; dok = 1'b0; allow = 1'b1; br_now = 1'b0;
        drive();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (f.inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", f.inst_sram_req); end
        checks++; if (f.fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", f.fs_to_ds_valid); end
        checks++; if (f.fs_to_ds_bus !== 64'h0) begin errors++; $display("FAIL reset_bus: got %h expected 0", f.fs_to_ds_bus); end
        checks++; if (f.inst_sram_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h expected %h", f.inst_sram_addr, RPC); end
        reset = 1'b0;
        #1;
        checks++; if (f.inst_sram_req !== 1'b0) begin errors++; $display("FAIL first_cycle_req: got %0b expected 0", f.inst_sram_req); end
        @(posedge clk);
        aok = 1'b1;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== RPC) begin errors++; $display("FAIL start_req: got req=%0b addr=%h expected req=1 addr=%h", s_req, s_addr, RPC); end
        aok = 1'b0;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== RPC + 32'd4) begin errors++; $display("FAIL pc_incr: got req=%0b addr=%h expected req=1 addr=%h", s_req, s_addr, RPC + 32'd4); end
    endtask

    task automatic test_stream();
        int nv = 0;
        do_reset();
        aok = 1'b1; dok = 1'b1; allow = 1'b1;
        for (int k = 0; k < 16; k++) exp_q.push_back(ent(RPC + 32'(4 * k)));
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i >= 2 && s_valid) nv++;
        end
        aok = 1'b0;
        repeat (4) tick();
        checks++; if (nv !== 14) begin errors++; $display("FAIL stream_throughput: got %0d valid cycles expected 14", nv); end
        checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g = got_q.pop_front();
            logic [63:0] e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL stream_data: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_full();
        int na = 0;
        do_reset();
        aok = 1'b1; dok = 1'b0; allow = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(ent(RPC + 32'(4 * k)));
        repeat (8) begin
            tick();
            if (s_req) na++;
        end
        checks++; if (na !== 4) begin errors++; $display("FAIL full_accepts: got %0d expected 4", na); end
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL full_req: got %0b expected 0", s_req); end
        dok = 1'b1;
        tick();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL full_req_dataok: got %0b expected 0", s_req); end
        dok = 1'b0;
        tick();
        checks++; if (s_valid !== 1'b1 || s_req !== 1'b0) begin errors++; $display("FAIL full_pop: got valid=%0b req=%0b expected valid=1 req=0", s_valid, s_req); end
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== RPC + 32'h10) begin errors++; $display("FAIL full_resume: got req=%0b addr=%h expected req=1 addr=%h", s_req, s_addr, RPC + 32'h10); end
        aok = 1'b0; dok = 1'b1;
        repeat (10) tick();
        checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL full_count: got %0d expected 5", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g = got_q.pop_front();
            logic [63:0] e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL full_data: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_branch();
        int nv;
        logic [31:0] tgt = RPC + 32'h100;
        do_reset();
        allow = 1'b1; dok = 1'b0; aok = 1'b1;
        tick(); tick();
        for (int k = 0; k < 6; k++) exp_q.push_back(ent(tgt + 32'(4 * k)));
        aok = 1'b0; dok = 1'b1; br_now = 1'b1; br_tgt = tgt;
        tick();
        checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL br_cycle: got req=%0b valid=%0b expected 0/0", s_req, s_valid); end
        aok = 1'b1;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== tgt) begin errors++; $display("FAIL br_redirect: got req=%0b addr=%h expected req=1 addr=%h", s_req, s_addr, tgt); end
        nv = int'(s_valid);
        tick();
        nv += int'(s_valid);
        checks++; if (nv !== 0) begin errors++; $display("FAIL br_squash: got %0d wrong-path valids expected 0", nv); end
        repeat (4) tick();
        aok = 1'b0;
        repeat (6) tick();
        checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL br_count: got %0d expected 6", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g = got_q.pop_front();
            logic [63:0] e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL br_data: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        allow = 1'b0; dok = 1'b1; aok = 1'b1;
        exp_q.push_back(ent(RPC));
        exp_q.push_back(ent(RPC + 32'd4));
        tick(); tick();
        aok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (s_valid !== 1'b1 || s_bus !== ent(RPC)) begin errors++; $display("FAIL stall_hold: got valid=%0b bus=%h expected valid=1 bus=%h", s_valid, s_bus, ent(RPC)); end
        end
        allow = 1'b1;
        repeat (5) tick();
        checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d expected 2", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [63:0] g = got_q.pop_front();
            logic [63:0] e = exp_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL stall_data: got %h expected %h", g, e); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        aok = 1'b1; dok = 1'b0; allow = 1'b1;
        repeat (3) tick();
        aok = 1'b0; dok = 1'b1;
        tick();
        @(negedge clk);
        drive();
        #1;
        checks++; if (f.fs_to_ds_valid !== 1'b1 || f.inst_sram_req !== 1'b1) begin errors++; $display("FAIL pre_reset: got valid=%0b req=%0b expected 1/1", f.fs_to_ds_valid, f.inst_sram_req); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (f.fs_to_ds_valid !== 1'b0 || f.inst_sram_req !== 1'b0) begin errors++; $display("FAIL async_drop: got valid=%0b req=%0b expected 0/0", f.fs_to_ds_valid, f.inst_sram_req); end
        checks++; if (f.fs_to_ds_bus !== 64'h0 || f.inst_sram_addr !== RPC) begin errors++; $display("FAIL async_state: got bus=%h addr=%h expected 0/%h", f.fs_to_ds_bus, f.inst_sram_addr, RPC); end
        dok = 1'b0;
        sram_q.delete(); got_q.delete();
        drive();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        aok = 1'b1;
        tick();
        checks++; if (s_req !== 1'b1 || s_addr !== RPC) begin errors++; $display("FAIL restart: got req=%0b addr=%h expected req=1 addr=%h", s_req, s_addr, RPC); end
        aok = 1'b0;
    endtask

    initial begin
        drive();
        test_reset();
        test_stream();
        test_full();
        test_branch();
        test_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
